mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Byte-serial memory controller between the core and the 8-bit unified RAM/IO port.
//  Serves two clients:
//   - Instruction fetch: 4-byte reads only, level request.
//   - LS execute unit: 1/2/4-byte reads/writes, one-cycle request pulse.
//  Splits each access into per-byte RAM cycles, assembles read data little-endian, and
//  returns a one-cycle ok pulse to the requester.
// PARAMETERS
//  ADDR_LEN  32        address width
//  DATA_LEN  32        data width
//  IO_BASE   32'h30000 addresses >= IO_BASE are IO space (write stall applies)
// PORTS
//  clk               in   1         clock
//  rst               in   1         asynchronous reset, active high
//  rollback          in   1         squash any pending/in-flight fetch (LS unaffected)
//  ena_from_if       in   1         fetch request, held high until ok_to_if
//  addr_from_if      in   ADDR_LEN  fetch address
//  ok_to_if          out  1         one-cycle pulse: data_to_if valid
//  data_to_if        out  DATA_LEN  fetched word
//  ena_from_ls       in   1         LS request, single-cycle pulse
//  addr_from_ls      in   ADDR_LEN  LS address
//  data_from_ls      in   DATA_LEN  store data (low size bytes used)
//  wr_flag_from_ls   in   1         1 = write, 0 = read
//  size_from_ls      in   3         bytes: 1, 2 or 4
//  ok_to_ls          out  1         one-cycle pulse: LS access done (data_to_ls valid for reads)
//  data_to_ls        out  DATA_LEN  load data, zero-extended (sign extension is downstream)
//  mem_din           in   8         RAM read byte (for mem_a of previous cycle)
//  mem_dout          out  8         RAM write byte
//  mem_a             out  ADDR_LEN  RAM byte address
//  mem_wr            out  1         1 = write this cycle
//  io_buffer_full    in   1         IO output buffer full
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, ls_pending = 0, all counters 0.
//  LS request latch:
//   - Rising-edge sample of ena_from_ls sets ls_pending.
//   - Addr, data, wr_flag and size are captured in the same cycle, even while busy.
//   - At most one LS request is outstanding; LS issues no new request before ok_to_ls.
//  States:
//   - IDLE -> LS_READ or LS_WRITE when ls_pending. LS has priority over fetch.
//   - IDLE -> IF_READ when ena_from_if && !rollback.
//   - Leaving IDLE clears ls_pending (LS case) and loads byte counter cnt = 0.
//  Read (N bytes):
//   - Cycle k drives mem_a = base + k, mem_wr = 0, for k = 0..N-1.
//   - mem_din in cycle k+1 is byte k, stored in result[8k+7:8k].
//   - ok pulses in the cycle after byte N-1 is captured, i.e. N+1 cycles after leaving IDLE.
//   - Unused upper bytes are 0.
//  Write (N bytes):
//   - Cycle k drives mem_a = base + k, mem_dout = data[8k+7:8k], mem_wr = 1.
//   - ok_to_ls pulses in the cycle after the last byte write.
//  Completion:
//   - State returns to IDLE on the same edge that raises ok.
//   - ok is low in every other cycle; data_to_* hold until the next completion.
//  Idle outputs: mem_wr = 0, mem_a = 0, mem_dout = 0.
//  Rollback:
//   - In IF_READ: abort at the next edge; no ok_to_if; back to IDLE.
//   - A latched ls_pending is kept.
//   - In LS states: ignored.
//  Simultaneous ena_from_ls pulse and IF request in IDLE: LS wins; fetch waits.
//  Address wrap: base + k wraps modulo 2^ADDR_LEN.
// CONFIGURATION
//  IO_STALL_EN:
//   - Defined: in LS_WRITE, if addr >= IO_BASE and io_buffer_full == 1, drive mem_wr = 0.
//     cnt holds and the byte is retried each cycle until io_buffer_full == 0.
//   - Undefined: io_buffer_full is ignored; writes never stall.
// TESTING
//  1. RAM[0x100..0x103] = 78 56 34 12; IF req 0x100 -> ok_to_if 5 cycles later, data_to_if = 0x12345678.
//  2. LS pulse SW 0x200 data 0xA1B2C3D4 -> 4 writes D4,C3,B2,A1 at 0x200..0x203;
//     one ok_to_ls 4 cycles after acceptance.
//  3. LS LB at 0x101 (RAM 0x56) -> data_to_ls = 0x00000056.
//     LH at 0x102 -> data_to_ls = 0x00001234.
//  4. IF request and LS pulse in the same IDLE cycle -> LS served first.
//     IF then served with no lost or duplicate ok pulses.
//  5. Rollback 2 cycles into IF_READ -> no ok_to_if, IDLE next cycle.
//     A pending LW completes normally afterwards.
//  6. IO_STALL_EN defined, SB 0x30000 with io_buffer_full high 3 cycles -> mem_wr held 0 for 3 cycles.
//     Then one write, then ok_to_ls.
//     With IO_STALL_EN undefined -> written immediately.
//  7. Async rst asserted mid LS_WRITE -> all outputs 0 immediately; no ok after release.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits fetch and load/store accesses into RAM byte cycles.
// Optional macro IO_STALL_EN holds IO-space writes while the IO output buffer is full.
module mem_ctrl #(
  parameter int          ADDR_LEN = 32,
  parameter int          DATA_LEN = 32,
  parameter logic [31:0] IO_BASE  = 32'h0003_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rollback,
  input  logic                ena_from_if,
  input  logic [ADDR_LEN-1:0] addr_from_if,
  output logic                ok_to_if,
  output logic [DATA_LEN-1:0] data_to_if,
  input  logic                ena_from_ls,
  input  logic [ADDR_LEN-1:0] addr_from_ls,
  input  logic [DATA_LEN-1:0] data_from_ls,
  input  logic                wr_flag_from_ls,
  input  logic [2:0]          size_from_ls,
  output logic                ok_to_ls,
  output logic [DATA_LEN-1:0] data_to_ls,
  input  logic [7:0]          mem_din,
  output logic [7:0]          mem_dout,
  output logic [ADDR_LEN-1:0] mem_a,
  output logic                mem_wr,
  input  logic                io_buffer_full
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_READ = 2'd1, LS_READ = 2'd2, LS_WRITE = 2'd3} state_t;

  state_t              r_state;
  logic [2:0]          r_cnt, r_len, r_ls_size;
  logic [ADDR_LEN-1:0] r_base, r_ls_addr;
  logic [DATA_LEN-1:0] r_ls_data, r_buf;
  logic                r_ls_wr, r_ls_pending, r_ena_ls_d;

  logic                w_ls_rise, w_ls_req, w_ls_wr;
  logic [ADDR_LEN-1:0] w_ls_addr, w_next_a;
  logic [DATA_LEN-1:0] w_ls_data, w_buf_next;
  logic [2:0]          w_ls_size, w_cnt_inc;
  logic [1:0]          w_rd_idx;
  logic                w_stall_first, w_stall_next;

  function automatic logic [DATA_LEN-1:0] place_byte(input logic [7:0] b, input logic [1:0] idx);
    return DATA_LEN'(b) << {idx, 3'b000};
  endfunction

  function automatic logic [7:0] byte_of(input logic [DATA_LEN-1:0] d, input logic [1:0] idx);
    return 8'(d >> {idx, 3'b000});
  endfunction

  // Request decode: a fresh LS pulse is usable in the same cycle it arrives.
  always_comb begin
    w_ls_rise  = ena_from_ls & ~r_ena_ls_d;
    w_ls_req   = r_ls_pending | w_ls_rise;
    w_ls_addr  = w_ls_rise ? addr_from_ls    : r_ls_addr;
    w_ls_data  = w_ls_rise ? data_from_ls    : r_ls_data;
    w_ls_wr    = w_ls_rise ? wr_flag_from_ls : r_ls_wr;
    w_ls_size  = w_ls_rise ? size_from_ls    : r_ls_size;
    w_cnt_inc  = r_cnt + 3'd1;
    w_next_a   = r_base + ADDR_LEN'(w_cnt_inc);
    w_rd_idx   = r_cnt[1:0] - 2'd1;
    w_buf_next = r_buf | place_byte(mem_din, w_rd_idx);
`ifdef IO_STALL_EN
    w_stall_first = io_buffer_full && (w_ls_addr >= ADDR_LEN'(IO_BASE));
    w_stall_next  = io_buffer_full && ((mem_wr ? w_next_a : mem_a) >= ADDR_LEN'(IO_BASE));
`else
    w_stall_first = 1'b0 & io_buffer_full;
    w_stall_next  = 1'b0;
`endif
  end

  // Main FSM with registered RAM-side and client-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_len        <= 3'd0;
      r_base       <= '0;
      r_buf        <= '0;
      r_ls_addr    <= '0;
      r_ls_data    <= '0;
      r_ls_size    <= 3'd0;
      r_ls_wr      <= 1'b0;
      r_ls_pending <= 1'b0;
      r_ena_ls_d   <= 1'b0;
      ok_to_if     <= 1'b0;
      data_to_if   <= '0;
      ok_to_ls     <= 1'b0;
      data_to_ls   <= '0;
      mem_dout     <= 8'd0;
      mem_a        <= '0;
      mem_wr       <= 1'b0;
    end else begin
      r_ena_ls_d <= ena_from_ls;
      ok_to_if   <= 1'b0;
      ok_to_ls   <= 1'b0;
      if (w_ls_rise) begin
        r_ls_pending <= 1'b1;
        r_ls_addr    <= addr_from_ls;
        r_ls_data    <= data_from_ls;
        r_ls_wr      <= wr_flag_from_ls;
        r_ls_size    <= size_from_ls;
      end
      case (r_state)
        IDLE: begin
          r_cnt    <= 3'd0;
          r_buf    <= '0;
          mem_wr   <= 1'b0;
          mem_a    <= '0;
          mem_dout <= 8'd0;
          if (w_ls_req) begin
            r_ls_pending <= 1'b0;
            r_base       <= w_ls_addr;
            r_len        <= w_ls_size;
            mem_a        <= w_ls_addr;
            if (w_ls_wr) begin
              r_state  <= LS_WRITE;
              mem_wr   <= ~w_stall_first;
              mem_dout <= w_ls_data[7:0];
            end else begin
              r_state <= LS_READ;
            end
          end else if (ena_from_if && !rollback) begin
            r_state <= IF_READ;
            r_base  <= addr_from_if;
            r_len   <= 3'd4;
            mem_a   <= addr_from_if;
          end else begin
            r_state <= IDLE;
          end
        end
        IF_READ, LS_READ: begin
          // Read data lags the address by one cycle, so byte k lands while cnt == k+1.
          if (r_state == IF_READ && rollback) begin
            r_state <= IDLE;
            mem_a   <= '0;
          end else if (r_cnt == r_len) begin
            r_state <= IDLE;
            mem_a   <= '0;
            if (r_state == IF_READ) begin
              ok_to_if   <= 1'b1;
              data_to_if <= w_buf_next;
            end else begin
              ok_to_ls   <= 1'b1;
              data_to_ls <= w_buf_next;
            end
          end else begin
            if (r_cnt != 3'd0) begin
              r_buf <= w_buf_next;
            end
            r_cnt <= w_cnt_inc;
            mem_a <= w_next_a;
          end
        end
        LS_WRITE: begin
          if (!mem_wr) begin
            mem_wr <= ~w_stall_next;
          end else if (w_cnt_inc == r_len) begin
            r_state  <= IDLE;
            ok_to_ls <= 1'b1;
            mem_wr   <= 1'b0;
            mem_a    <= '0;
            mem_dout <= 8'd0;
          end else begin
            r_cnt    <= w_cnt_inc;
            mem_a    <= w_next_a;
            mem_dout <= byte_of(r_ls_data, w_cnt_inc[1:0]);
            mem_wr   <= ~w_stall_next;
          end
        end
        default: begin
          r_state <= IDLE;
          mem_wr  <= 1'b0;
          mem_a   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected read words and write bytes are queued at stimulus
// time and checked when the DUT raises ok pulses or RAM writes.
module tb_mem_ctrl;
  logic        clk, rst, rollback;
  logic        ena_from_if, ok_to_if, ena_from_ls, wr_flag_from_ls, ok_to_ls;
  logic [31:0] addr_from_if, data_to_if, addr_from_ls, data_from_ls, data_to_ls, mem_a;
  logic [2:0]  size_from_ls;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr, io_buffer_full;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_ls[$];
  logic [39:0] exp_wr[$];
  logic [7:0]  ram[0:4095];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rollback(rollback),
    .ena_from_if(ena_from_if), .addr_from_if(addr_from_if),
    .ok_to_if(ok_to_if), .data_to_if(data_to_if),
    .ena_from_ls(ena_from_ls), .addr_from_ls(addr_from_ls), .data_from_ls(data_from_ls),
    .wr_flag_from_ls(wr_flag_from_ls), .size_from_ls(size_from_ls),
    .ok_to_ls(ok_to_ls), .data_to_ls(data_to_ls),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears one cycle after the address.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  // Scoreboard monitors
  always @(negedge clk) begin : mon
    logic [31:0] e;
    logic [39:0] w;
    if (!rst) begin
      if (ok_to_if === 1'b1) begin
        n_tests++;
        if (exp_if.size() == 0) begin
          n_fail++; $display("FAIL if_unexpected_ok data=%h required=no pulse", data_to_if);
        end else begin
          e = exp_if.pop_front();
          if (data_to_if !== e) begin n_fail++; $display("FAIL if_data got=%h required=%h", data_to_if, e); end
        end
      end
      if (ok_to_ls === 1'b1) begin
        n_tests++;
        if (exp_ls.size() == 0) begin
          n_fail++; $display("FAIL ls_unexpected_ok data=%h required=no pulse", data_to_ls);
        end else begin
          e = exp_ls.pop_front();
          if (e !== 32'hFFFF_FFFF && data_to_ls !== e) begin
            n_fail++; $display("FAIL ls_data got=%h required=%h", data_to_ls, e);
          end
        end
      end
      if (mem_wr === 1'b1) begin
        n_tests++;
        if (exp_wr.size() == 0) begin
          n_fail++; $display("FAIL unexpected_write addr=%h byte=%h required=no write", mem_a, mem_dout);
        end else begin
          w = exp_wr.pop_front();
          if ({mem_a, mem_dout} !== w) begin
            n_fail++; $display("FAIL write got=%h/%h required=%h/%h", mem_a, mem_dout, w[39:8], w[7:0]);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    ena_from_if = 1'b0; addr_from_if = 32'd0; rollback = 1'b0;
    ena_from_ls = 1'b0; addr_from_ls = 32'd0; data_from_ls = 32'd0;
    wr_flag_from_ls = 1'b0; size_from_ls = 3'd0; io_buffer_full = 1'b0;
  endtask

  task automatic ls_start(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic [2:0] sz);
    ena_from_ls = 1'b1; addr_from_ls = a; data_from_ls = d; wr_flag_from_ls = wr; size_from_ls = sz;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({ok_to_if, data_to_if, ok_to_ls, data_to_ls, mem_dout, mem_a, mem_wr} !== 107'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h required=0", {data_to_if, data_to_ls, mem_a, mem_dout});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({mem_a, mem_wr, ok_to_if, ok_to_ls} !== 35'd0) begin
      n_fail++; $display("FAIL idle_outputs mem_a=%h mem_wr=%b required=0/0", mem_a, mem_wr);
    end
  endtask

  task automatic test_if_read();
    bit seen = 0;
    @(negedge clk);
    exp_if.push_back(32'h1234_5678);
    ena_from_if = 1'b1; addr_from_if = 32'h100;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        n_tests++;
        if (mem_a !== 32'h100 || mem_wr !== 1'b0) begin
          n_fail++; $display("FAIL if_first_addr got=%h/%b required=00000100/0", mem_a, mem_wr);
        end
      end
      if (ok_to_if === 1'b1) begin
        seen = 1; ena_from_if = 1'b0; n_tests++;
        if (cyc != 6) begin n_fail++; $display("FAIL if_latency got=%0d required=6", cyc); end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL if_timeout got=no ok required=ok"); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_ls_write();
    bit seen = 0;
    @(negedge clk);
    exp_wr.push_back({32'h200, 8'hD4}); exp_wr.push_back({32'h201, 8'hC3});
    exp_wr.push_back({32'h202, 8'hB2}); exp_wr.push_back({32'h203, 8'hA1});
    exp_ls.push_back(32'hFFFF_FFFF);
    ls_start(32'h200, 32'hA1B2_C3D4, 1'b1, 3'd4);
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      ena_from_ls = 1'b0;
      if (ok_to_ls === 1'b1) begin
        seen = 1; n_tests++;
        if (cyc != 5) begin n_fail++; $display("FAIL sw_latency got=%0d required=5", cyc); end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL sw_timeout got=no ok required=ok"); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_ls_read(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp_d, input int exp_cyc);
    bit seen = 0;
    @(negedge clk);
    exp_ls.push_back(exp_d);
    ls_start(a, 32'hDEAD_BEEF, 1'b0, sz);
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      ena_from_ls = 1'b0;
      if (ok_to_ls === 1'b1) begin
        seen = 1; n_tests++;
        if (cyc != exp_cyc) begin n_fail++; $display("FAIL ls_read_latency got=%0d required=%0d", cyc, exp_cyc); end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL ls_read_timeout got=no ok required=ok"); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_priority();
    int ls_cyc = 0, if_cyc = 0;
    @(negedge clk);
    exp_ls.push_back(32'h0000_1234);
    exp_if.push_back(32'h1234_5678);
    ena_from_if = 1'b1; addr_from_if = 32'h100;
    ls_start(32'h102, 32'd0, 1'b0, 3'd2);
    for (int cyc = 1; cyc <= 30 && if_cyc == 0; cyc++) begin
      @(posedge clk); #1;
      ena_from_ls = 1'b0;
      if (ok_to_ls === 1'b1) ls_cyc = cyc;
      if (ok_to_if === 1'b1) begin if_cyc = cyc; ena_from_if = 1'b0; end
    end
    n_tests++;
    if (ls_cyc != 4 || if_cyc != 10) begin
      n_fail++; $display("FAIL priority_order got ls=%0d if=%0d required ls=4 if=10", ls_cyc, if_cyc);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_rollback();
    bit seen = 0;
    @(negedge clk);
    exp_ls.push_back(32'hA1B2_C3D4);
    ena_from_if = 1'b1; addr_from_if = 32'h100;
    for (int cyc = 1; cyc <= 25 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) ls_start(32'h200, 32'd0, 1'b0, 3'd4);
      if (cyc == 2) begin ena_from_ls = 1'b0; rollback = 1'b1; ena_from_if = 1'b0; end
      if (cyc == 3) begin
        rollback = 1'b0; n_tests++;
        if (mem_a !== 32'd0 || ok_to_if !== 1'b0) begin
          n_fail++; $display("FAIL rollback_idle mem_a=%h ok=%b required=0/0", mem_a, ok_to_if);
        end
      end
      if (cyc == 4) begin
        n_tests++;
        if (mem_a !== 32'h200) begin n_fail++; $display("FAIL rollback_ls_addr got=%h required=00000200", mem_a); end
      end
      if (ok_to_ls === 1'b1) begin
        seen = 1; n_tests++;
        if (cyc != 9) begin n_fail++; $display("FAIL rollback_ls_latency got=%0d required=9", cyc); end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL rollback_timeout got=no ok required=ok"); end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_io_stall();
    bit seen = 0;
    int wr_cyc = 0;
`ifdef IO_STALL_EN
    int exp_wr_cyc = 4, exp_ok = 5;
`else
    int exp_wr_cyc = 1, exp_ok = 2;
`endif
    @(negedge clk);
    exp_wr.push_back({32'h0003_0000, 8'h5A});
    exp_ls.push_back(32'hFFFF_FFFF);
    io_buffer_full = 1'b1;
    ls_start(32'h0003_0000, 32'h0000_005A, 1'b1, 3'd1);
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      ena_from_ls = 1'b0;
      if (cyc == 3) io_buffer_full = 1'b0;
      if (mem_wr === 1'b1 && wr_cyc == 0) wr_cyc = cyc;
      if (ok_to_ls === 1'b1) begin
        seen = 1; n_tests++;
        if (cyc != exp_ok || wr_cyc != exp_wr_cyc) begin
          n_fail++; $display("FAIL io_stall got wr=%0d ok=%0d required wr=%0d ok=%0d", wr_cyc, cyc, exp_wr_cyc, exp_ok);
        end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL io_stall_timeout got=no ok required=ok"); end
    io_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_midwrite();
    bit bad_ok = 0;
    @(negedge clk);
    exp_wr.push_back({32'h300, 8'h44}); exp_wr.push_back({32'h301, 8'h33});
    ls_start(32'h300, 32'h1122_3344, 1'b1, 3'd4);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
      ena_from_ls = 1'b0;
    end
    rst = 1'b1; #1;
    n_tests++;
    if ({ok_to_if, data_to_if, ok_to_ls, data_to_ls, mem_dout, mem_a, mem_wr} !== 107'd0) begin
      n_fail++; $display("FAIL async_reset got=%h/%h/%b required=0", data_to_ls, mem_a, mem_wr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (ok_to_ls === 1'b1 || ok_to_if === 1'b1 || mem_wr === 1'b1) bad_ok = 1;
    end
    n_tests++;
    if (bad_ok) begin n_fail++; $display("FAIL post_reset_activity got=activity required=none"); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    test_reset();
    test_if_read();
    test_ls_write();
    test_ls_read(32'h101, 3'd1, 32'h0000_0056, 3);
    test_ls_read(32'h102, 3'd2, 32'h0000_1234, 4);
    test_ls_read(32'h200, 3'd4, 32'hA1B2_C3D4, 6);
    test_priority();
    test_rollback();
    test_io_stall();
    test_reset_midwrite();
    n_tests++;
    if (exp_if.size() != 0 || exp_ls.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got if=%0d ls=%0d wr=%0d required=0/0/0", exp_if.size(), exp_ls.size(), exp_wr.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
